// File: rtl/inv_round_controller.sv
// ---------------------------------------------------------------------------
// inv_round_controller
//
// Sequencer for the AES-128 decryption datapath. It walks the cipher state
// register through the initial AddRoundKey (round NUM_ROUNDS) and the
// inverse rounds down to round 0. For each round it requests the round key
// from key storage over key_req/key_ack and enables the inverse round stages.
//
// Ports
//   clk, n_rst          clock (rising edge), async active-low reset
//   start               begin one block (sampled only in IDLE)
//   abort               synchronous cancel back to IDLE
//   key_ack             key storage presents the key for key_round
//   busy                block in progress (LOAD/FETCH)
//   done                one-cycle pulse, plaintext is in the state register
//   load_input          datapath captures ciphertext this cycle
//   key_req, key_round  round key request and its index
//   state_we            state register captures datapath output this cycle
//   inv_sub_enable, inv_shift_enable, inv_mix_enable, add_key_enable
//                       per-stage enables (stage is bypassed when 0)
//   round_num           current round counter
// ---------------------------------------------------------------------------
module inv_round_controller #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       abort,
    input  logic       key_ack,
    output logic       busy,
    output logic       done,
    output logic       load_input,
    output logic       key_req,
    output logic [3:0] key_round,
    output logic       state_we,
    output logic       inv_sub_enable,
    output logic       inv_shift_enable,
    output logic       inv_mix_enable,
    output logic       add_key_enable,
    output logic [3:0] round_num
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     nxt_state;
    logic [3:0] nxt_round;

    // Next-state / next-round. Abort wins over everything else and leaves
    // the round counter untouched.
    always_comb begin
        nxt_state = state;
        nxt_round = round_num;
        if (abort) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) nxt_state = LOAD;
                LOAD: begin
                    nxt_state = FETCH;
                    nxt_round = LAST;
                end
                FETCH: begin
                    if (key_ack) begin
                        if (round_num == 4'd0) nxt_state = DONE;
                        else                   nxt_round = round_num - 4'd1;
                    end
                end
                DONE:  nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Capture is tied directly to the key handshake so the state register
    // loads in the same cycle the key is on the bus. Not gated by abort.
    assign state_we = (state == FETCH) && key_ack;

    // Moore outputs are registered: decode them from the next state/round so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            round_num        <= 4'd0;
            key_round        <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            load_input       <= 1'b0;
            key_req          <= 1'b0;
            inv_sub_enable   <= 1'b0;
            inv_shift_enable <= 1'b0;
            inv_mix_enable   <= 1'b0;
            add_key_enable   <= 1'b0;
        end else begin
            state            <= nxt_state;
            round_num        <= nxt_round;
            key_round        <= nxt_round;
            busy             <= (nxt_state == LOAD) || (nxt_state == FETCH);
            done             <= (nxt_state == DONE);
            load_input       <= (nxt_state == LOAD);
            key_req          <= (nxt_state == FETCH);
            // Round NUM_ROUNDS is the bare initial AddRoundKey; round 0 is
            // the final round without inverse mix-columns.
            add_key_enable   <= (nxt_state == FETCH);
            inv_sub_enable   <= (nxt_state == FETCH) && (nxt_round != LAST);
            inv_shift_enable <= (nxt_state == FETCH) && (nxt_round != LAST);
            inv_mix_enable   <= (nxt_state == FETCH) && (nxt_round != LAST)
                                && (nxt_round != 4'd0);
        end
    end

endmodule
